// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : Run/step controller for the single-cycle MIPS core. Generates a
//            stretched synchronous core reset and a one-cycle clock-enable
//            (cpu_ce). Supports free-run, single-step and halt modes, and
//            counts retired cycles.
// Options  : CYCLE_LIMIT_EN adds cycle_limit input (auto-halt at a count)
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
  parameter int DIV      = 2,   // clkin cycles per cpu_ce tick (1..255)
  parameter int RST_HOLD = 4,   // cpu_rst stretch after reset release (1..255)
  parameter int CNT_W    = 32   // width of cycle_cnt
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             run_mode,
  input  logic             step_req,
  input  logic             halt_req,
`ifdef CYCLE_LIMIT_EN
  input  logic [CNT_W-1:0] cycle_limit,
`endif
  output logic             cpu_rst,
  output logic             cpu_ce,
  output logic             step_done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [7:0] c_DIV_LAST  = 8'(DIV - 1);
  localparam logic [7:0] c_HOLD_INIT = 8'(RST_HOLD);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_FIRE = 3'd3,
    S_STEP_DONE = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t           r_state;
  logic [7:0]       r_hold_cnt;
  logic [7:0]       r_div_cnt;
  logic             r_step_d;
  logic             r_cpu_rst;
  logic             r_cpu_ce;
  logic             r_step_done;
  logic             r_halted;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic             w_tick;
  logic             w_step_edge;
  logic             w_halt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_tick      = (r_div_cnt == c_DIV_LAST);
  assign w_step_edge = step_req & ~r_step_d;
  assign w_cnt_inc   = r_cycle_cnt + CNT_W'(1);

`ifdef CYCLE_LIMIT_EN
  // Set one cycle after the cpu_ce that reaches the limit, so the halt takes
  // effect before another enable can be issued.
  logic r_limit_hit;
  logic w_limit_match;
  assign w_limit_match = (cycle_limit != '0) && (w_cnt_inc == cycle_limit);
  assign w_halt        = halt_req | r_limit_hit;
`else
  assign w_halt        = halt_req;
`endif

  // Free-running tick divider; parked at zero while the core is held in reset
  always_ff @(posedge clkin) begin
    if (reset || (r_state == S_HOLD)) begin
      r_div_cnt <= 8'd0;
    end else if (w_tick) begin
      r_div_cnt <= 8'd0;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  // Run/step state machine with registered core-facing outputs
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state     <= S_HOLD;
      r_hold_cnt  <= c_HOLD_INIT;
      r_step_d    <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_cpu_ce    <= 1'b0;
      r_step_done <= 1'b0;
      r_halted    <= 1'b0;
      r_cycle_cnt <= '0;
`ifdef CYCLE_LIMIT_EN
      r_limit_hit <= 1'b0;
`endif
    end else begin
      r_step_d    <= step_req;
      r_cpu_ce    <= 1'b0;
      r_step_done <= 1'b0;
      case (r_state)
        S_HOLD: begin
          if (r_hold_cnt <= 8'd1) begin
            r_cpu_rst <= 1'b0;
            r_state   <= run_mode ? S_RUN : S_STEP_WAIT;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        S_RUN: begin
          // Halt and mode change both suppress the enable on the exit edge
          if (w_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (!run_mode) begin
            r_state <= S_STEP_WAIT;
          end else if (w_tick) begin
            r_cpu_ce    <= 1'b1;
            r_cycle_cnt <= w_cnt_inc;
`ifdef CYCLE_LIMIT_EN
            if (w_limit_match) r_limit_hit <= 1'b1;
`endif
          end
        end
        S_STEP_WAIT: begin
          if (w_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (run_mode) begin
            r_state <= S_RUN;
          end else if (w_step_edge) begin
            r_state <= S_STEP_FIRE;
          end
        end
        S_STEP_FIRE: begin
          if (w_tick) begin
            r_cpu_ce    <= 1'b1;
            r_cycle_cnt <= w_cnt_inc;
            r_state     <= S_STEP_DONE;
`ifdef CYCLE_LIMIT_EN
            if (w_limit_match) r_limit_hit <= 1'b1;
`endif
          end
        end
        S_STEP_DONE: begin
          r_step_done <= 1'b1;
          if (w_halt) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else if (run_mode) begin
            r_state <= S_RUN;
          end else begin
            r_state <= S_STEP_WAIT;
          end
        end
        S_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state    <= S_HOLD;
          r_hold_cnt <= c_HOLD_INIT;
          r_cpu_rst  <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rst   = r_cpu_rst;
  assign cpu_ce    = r_cpu_ce;
  assign step_done = r_step_done;
  assign halted    = r_halted;
  assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire
